// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder
//  Purpose  : Registered N-to-2^N one-hot decoder with two modes.
//             Direct mode loads a validated index; scan mode walks the active
//             line through all 2^N outputs at a programmable rate and pulses
//             wrap when the walk returns to line 0.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous active-high reset
//             en        - global enable, 0 freezes all state
//             mode      - 0 direct decode, 1 auto-scan
//             in_valid  - direct-mode load strobe
//             in        - direct-mode index
//             div       - scan period minus 1
//             out       - registered one-hot lines (polarity per ACTIVE_LOW)
//             idx       - currently selected index
//             out_valid - out holds a decoded value
//             wrap      - one-cycle pulse on scan wrap to index 0
//  Revision : 1.0 - initial release
// ============================================================================
module scan_decoder #(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int DIV_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in,
  input  logic [DIV_W-1:0]    div,
  output logic [(1<<N)-1:0]   out,
  output logic [N-1:0]        idx,
  output logic                out_valid,
  output logic                wrap
);

  localparam int c_LINES = 1 << N;

  logic [N-1:0]       r_idx;
  logic [DIV_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic               r_wrap;
  logic               r_mode_q;
  logic [c_LINES-1:0] r_out;

  logic [N-1:0]       w_idx_nxt;
  logic [DIV_W-1:0]   w_cnt_nxt;
  logic               w_valid_nxt;
  logic               w_wrap_nxt;
  logic               w_mode_nxt;
  logic [c_LINES-1:0] w_out_nxt;

  always_comb begin
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_out_valid;
    w_wrap_nxt  = 1'b0;
    w_mode_nxt  = r_mode_q;
    if (en) begin
      if (mode != r_mode_q) begin
        // Mode change edge: restart the prescaler, no load and no advance.
        w_cnt_nxt  = '0;
        w_mode_nxt = mode;
      end else if (!mode) begin
        w_cnt_nxt = '0;
        if (in_valid) begin
          w_idx_nxt   = in;
          w_valid_nxt = 1'b1;
        end
      end else begin
        // >= rather than == so a div lowered below cnt cannot lock the scan.
        if (r_cnt >= div) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + N'(1);
          w_valid_nxt = 1'b1;
          w_wrap_nxt  = (r_idx == {N{1'b1}});
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Decode from the next-state values so out updates on the same edge as idx.
  for (genvar g = 0; g < c_LINES; g++) begin : g_dec
    assign w_out_nxt[g] = (w_valid_nxt && (w_idx_nxt == N'(g))) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_mode_q    <= 1'b0;
      r_out       <= {c_LINES{ACTIVE_LOW}};
    end else begin
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_valid_nxt;
      r_wrap      <= w_wrap_nxt;
      r_mode_q    <= w_mode_nxt;
      r_out       <= w_out_nxt;
    end
  end

  assign out       = r_out;
  assign idx       = r_idx;
  assign out_valid = r_out_valid;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire
